escritor_filas: RTL and testbench
=================================

ESCRITOR_FILAS -- requirements
Module: escritor_filas

Interface
REQ-001 SHALL have parameter bit_depth, default 8, bits per pixel.
REQ-002 SHALL have parameter width_fil, default 16, rows per block.
REQ-003 SHALL have parameter width_col, default 16, pixels per row.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle request to load one block.
REQ-007 SHALL have port pix_in  input  bit_depth  incoming pixel.
REQ-008 SHALL have port pix_valid  input  1  pix_in valid.
REQ-009 SHALL have port pix_ready  output  1  block accepts pix_in this cycle.
REQ-010 SHALL have port fila_out  output  bit_depth*width_col  assembled row toward buffer_enteros fila_in.
REQ-011 SHALL have port wr  output  1  buffer mode: 0 = write, 1 = read.
REQ-012 SHALL have port en  output  1  buffer enable.
REQ-013 SHALL have port fila_idx  output  clog2(width_fil)  index of row currently written or read.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse when block readout completes.

Function
REQ-016 SHALL implement FSM states IDLE, CARGA, LECTURA, FIN.
REQ-017 IDLE -> CARGA on start=1; start ignored in all other states.
REQ-018 pix_ready SHALL be 1 only in CARGA; a pixel is accepted when pix_valid=1 and pix_ready=1.
REQ-019 Accepted pixel k of a row (k = 0..width_col-1, arrival order) SHALL occupy fila_out[bit_depth*k +: bit_depth].
REQ-020 On acceptance of pixel width_col-1, the completed row SHALL appear on fila_out with en=1, wr=0 in the next cycle, for exactly one cycle (latency 1).
REQ-021 Pixel acceptance SHALL continue without stall during the row-write cycle; no pixel lost or duplicated at row boundaries.
REQ-022 fila_idx SHALL equal the row number (0..width_fil-1) during each write cycle, wrapping to 0 afterward.
REQ-023 After the write cycle of row width_fil-1, FSM SHALL enter LECTURA; pix_ready=0 from the cycle after the last pixel accepted.
REQ-024 LECTURA SHALL hold en=1, wr=1 for exactly width_fil consecutive cycles, fila_idx counting 0..width_fil-1.
REQ-025 After LECTURA, FSM SHALL enter FIN for one cycle with done=1, en=0, then IDLE.
REQ-026 Outside write and read cycles, en SHALL be 0 and wr SHALL be 0.
REQ-027 pix_valid=0 gaps in CARGA SHALL stall assembly with no output change; en stays 0.
REQ-028 fila_out SHALL hold its last written row until the next row completes.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, fila_out=0, wr=0, en=0, fila_idx=0, pix_ready=0, busy=0, done=0, pixel and row counters 0.
REQ-030 Reset mid-CARGA or mid-LECTURA SHALL discard the partial block; after rst=1 the block waits for a new start.

Configuration
REQ-031 Macro ESCRITOR_FILAS_ERR_EN SHALL, when defined, add output err (1 bit), set sticky when start=1 while busy=1, cleared only by reset.
REQ-032 Without ESCRITOR_FILAS_ERR_EN, port err SHALL not exist and start while busy SHALL be silently ignored.

Verification
REQ-033 Defaults; start, then 256 pixels with value row index r (0..15) continuously -> 16 writes, each fila_out = 16 copies of r, en=1 wr=0, fila_idx=r.
REQ-034 Same block -> 16 cycles en=1 wr=1, then done=1 for one cycle, busy=0 next cycle; buffer_enteros readback equals written rows.
REQ-035 pix_valid toggling 1/0 every cycle -> identical rows as REQ-033, write pulses 32 cycles apart.
REQ-036 Pixels 0x00..0x0F into row 0 -> fila_out = 0x0F0E0D0C0B0A09080706050403020100.
REQ-037 rst=0 after 100 accepted pixels -> all outputs 0 immediately; new start and 256 pixels yield clean block.
REQ-038 With ESCRITOR_FILAS_ERR_EN, start pulsed during LECTURA -> err=1 and stays 1; block completes normally.

Source files
------------

// File: rtl/escritor_filas.sv
// Row writer: assembles incoming pixels into full rows, writes each row to the buffer,
// then reads the whole block back. Optional sticky error output under ESCRITOR_FILAS_ERR_EN.
module escritor_filas #(
    parameter int bit_depth = 8,
    parameter int width_fil = 16,
    parameter int width_col = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [bit_depth-1:0]            pix_in,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [bit_depth*width_col-1:0]  fila_out,
    output logic                            wr,
    output logic                            en,
    output logic [$clog2(width_fil)-1:0]    fila_idx,
    output logic                            busy,
    output logic                            done
`ifdef ESCRITOR_FILAS_ERR_EN
    ,
    output logic                            err
`endif
);

    localparam int CW  = $clog2(width_col);
    localparam int FIW = $clog2(width_fil);
    localparam int RW  = bit_depth * width_col;
    localparam logic [CW-1:0]  PIX_LAST  = CW'(width_col - 1);
    localparam logic [FIW-1:0] FILA_LAST = FIW'(width_fil - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CARGA   = 2'd1,
        LECTURA = 2'd2,
        FIN     = 2'd3
    } estado_t;

    estado_t              r_estado;
    estado_t              w_estado_sig;
    logic [CW-1:0]        r_pix_cnt;
    logic [FIW-1:0]       r_fila_cnt;
    logic [FIW-1:0]       r_rd_cnt;
    logic [FIW-1:0]       r_wr_idx;
    logic                 r_wr_pulso;
    logic                 r_lleno;
    logic [RW-bit_depth-1:0] r_asm;
    logic [RW-1:0]        r_fila;
    logic                 w_acepta;
    logic                 w_fin_fila;
    logic                 w_fin_bloque;

    assign pix_ready    = (r_estado == CARGA) && !r_lleno;
    assign w_acepta     = pix_valid && pix_ready;
    assign w_fin_fila   = w_acepta && (r_pix_cnt == PIX_LAST);
    assign w_fin_bloque = w_fin_fila && (r_fila_cnt == FILA_LAST);

    assign fila_out = r_fila;
    assign wr       = (r_estado == LECTURA);
    assign en       = r_wr_pulso || (r_estado == LECTURA);
    assign fila_idx = (r_estado == LECTURA) ? r_rd_cnt : r_wr_idx;
    assign busy     = (r_estado != IDLE);
    assign done     = (r_estado == FIN);

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            IDLE:    if (start) w_estado_sig = CARGA;
            // r_lleno marks the write cycle of the last row; leave CARGA right after it
            CARGA:   if (r_lleno) w_estado_sig = LECTURA;
            LECTURA: if (r_rd_cnt == FILA_LAST) w_estado_sig = FIN;
            FIN:     w_estado_sig = IDLE;
            default: w_estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_estado <= IDLE;
        else      r_estado <= w_estado_sig;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_cnt  <= '0;
            r_fila_cnt <= '0;
            r_rd_cnt   <= '0;
            r_wr_idx   <= '0;
            r_wr_pulso <= 1'b0;
            r_lleno    <= 1'b0;
            r_fila     <= '0;
        end else begin
            r_wr_pulso <= w_fin_fila;
            r_wr_idx   <= w_fin_fila ? r_fila_cnt : '0;
            r_lleno    <= w_fin_bloque;
            if (w_fin_fila)
                r_fila <= {pix_in, r_asm};
            if (w_acepta)
                r_pix_cnt <= w_fin_fila ? '0 : r_pix_cnt + 1'b1;
            if (w_fin_fila)
                r_fila_cnt <= w_fin_bloque ? '0 : r_fila_cnt + 1'b1;
            if (r_estado == LECTURA)
                r_rd_cnt <= (r_rd_cnt == FILA_LAST) ? '0 : r_rd_cnt + 1'b1;
        end
    end

    // The last pixel of a row goes straight into r_fila, so r_asm holds only the first width_col-1
    always_ff @(posedge clk) begin
        if (w_acepta && !w_fin_fila)
            r_asm[bit_depth*r_pix_cnt +: bit_depth] <= pix_in;
    end

`ifdef ESCRITOR_FILAS_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_err <= 1'b0;
        else      r_err <= r_err || (start && busy);
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_escritor_filas.sv
// Scoreboard bench for escritor_filas: expected buffer writes/reads are queued as pixels
// are driven and popped when the DUT raises en.
module tb_escritor_filas;

    localparam int BD = 8;
    localparam int WF = 16;
    localparam int WC = 16;
    localparam int FW = BD * WC;
    localparam int IW = $clog2(WF);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BD-1:0] pix_in;
    logic          pix_valid;
    logic          pix_ready;
    logic [FW-1:0] fila_out;
    logic          wr;
    logic          en;
    logic [IW-1:0] fila_idx;
    logic          busy;
    logic          done;
`ifdef ESCRITOR_FILAS_ERR_EN
    logic          err;
`endif

    escritor_filas #(.bit_depth(BD), .width_fil(WF), .width_col(WC)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .fila_out  (fila_out),
        .wr        (wr),
        .en        (en),
        .fila_idx  (fila_idx),
        .busy      (busy),
        .done      (done)
`ifdef ESCRITOR_FILAS_ERR_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] fila;
        logic [IW-1:0] idx;
        logic          wr;
        logic          last;
    } ev_t;

    ev_t           q[$];
    int            wcyc[$];
    logic [FW-1:0] wrows[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic          exp_done = 1'b0;
    logic          exp_idle = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (exp_idle) begin
                    chk("busy_after_done", FW'(busy), FW'(0));
                    exp_idle = 1'b0;
                end
                if (exp_done) begin
                    chk("done_pulse", FW'(done), FW'(1));
                    chk("en_at_done", FW'(en), FW'(0));
                    exp_done = 1'b0;
                    exp_idle = 1'b1;
                end else if (done) begin
                    chk("done_spurious", FW'(done), FW'(0));
                end
                if (en) begin
                    if (q.size() == 0) begin
                        chk("en_spurious", FW'(en), FW'(0));
                    end else begin
                        e = q.pop_front();
                        chk("wr_mode", FW'(wr), FW'(e.wr));
                        chk(e.wr ? "rd_idx" : "wr_idx", FW'(fila_idx), FW'(e.idx));
                        if (!e.wr) begin
                            chk("fila", fila_out, e.fila);
                            wcyc.push_back(cyc);
                            wrows.push_back(fila_out);
                        end
                        if (e.last) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: every pixel of row r is r; mode 1: row 0 carries 0..WC-1
    task automatic send_block(input int mode, input bit toggle, input int stop_after);
        int k = 0;
        int r = 0;
        int acc = 0;
        int guard = 0;
        logic [FW-1:0] row = '0;
        logic [BD-1:0] p;
        while (r < WF && acc != stop_after && guard < 4000) begin
            @(negedge clk);
            guard++;
            p = (mode == 1 && r == 0) ? k[BD-1:0] : r[BD-1:0];
            pix_in    = p;
            pix_valid = toggle ? (guard % 2 == 1) : 1'b1;
            if (pix_valid && pix_ready) begin
                row[BD*k +: BD] = p;
                acc++;
                if (k == WC - 1) begin
                    q.push_back('{row, r[IW-1:0], 1'b0, 1'b0});
                    k = 0;
                    r++;
                end else begin
                    k++;
                end
            end
        end
        if (stop_after < 0) begin
            for (int i = 0; i < WF; i++)
                q.push_back('{'0, i[IW-1:0], 1'b1, (i == WF - 1)});
            chk("pix_accepted", FW'(acc), FW'(WF * WC));
        end
        @(negedge clk);
        pix_valid = 1'b0;
        if (stop_after < 0)
            chk("ready_low_after_last", FW'(pix_ready), FW'(0));
    endtask

    task automatic wait_done();
        int g = 0;
        while ((q.size() != 0 || exp_done || exp_idle) && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (2) @(negedge clk);
        chk("pending_events", FW'(q.size()), FW'(0));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("rst_fila_out", fila_out, '0);
        chk("rst_en", FW'(en), FW'(0));
        chk("rst_busy", FW'(busy), FW'(0));
        chk("rst_ready", FW'(pix_ready), FW'(0));
        @(negedge clk);
        rst = 1'b1;

        // continuous block, row r filled with r
        pulse_start();
        send_block(0, 1'b0, -1);
        wait_done();

        // pix_valid toggling every cycle
        wcyc.delete();
        pulse_start();
        send_block(0, 1'b1, -1);
        wait_done();
        for (int i = 1; i < 4; i++)
            chk("write_gap", FW'(wcyc[i] - wcyc[i-1]), FW'(32));

        // ramp row 0, plus a start pulse during readout
        wrows.delete();
        pulse_start();
        send_block(1, 1'b0, -1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef ESCRITOR_FILAS_ERR_EN
        chk("err_set", FW'(err), FW'(1));
`endif
        wait_done();
        chk("ramp_row0", wrows[0], 128'h0F0E0D0C0B0A09080706050403020100);
`ifdef ESCRITOR_FILAS_ERR_EN
        chk("err_sticky", FW'(err), FW'(1));
`endif

        // reset after 100 accepted pixels
        pulse_start();
        send_block(0, 1'b0, 100);
        #2 rst = 1'b0;
        #1;
        q.delete();
        exp_done = 1'b0;
        exp_idle = 1'b0;
        chk("mid_rst_fila_out", fila_out, '0);
        chk("mid_rst_en", FW'(en), FW'(0));
        chk("mid_rst_wr", FW'(wr), FW'(0));
        chk("mid_rst_idx", FW'(fila_idx), FW'(0));
        chk("mid_rst_ready", FW'(pix_ready), FW'(0));
        chk("mid_rst_busy", FW'(busy), FW'(0));
        chk("mid_rst_done", FW'(done), FW'(0));
`ifdef ESCRITOR_FILAS_ERR_EN
        chk("mid_rst_err", FW'(err), FW'(0));
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_rst", FW'(busy), FW'(0));
        pulse_start();
        send_block(0, 1'b0, -1);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
